// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register of the MIPS-Lite core: result select, stall/flush,
// misaligned-access detection, EX/MEM forwarding source and a bubble counter.
module ex_mem_stage #(
    parameter int unsigned DW        = 32,
    parameter logic [5:0]  SRL_FUNCT = 6'b000010,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [5:0]       ex_opcode,
    input  logic [5:0]       ex_funct,
    input  logic [DW-1:0]    alu_result,
    input  logic [DW-1:0]    shift_result,
    input  logic [DW-1:0]    ex_store_data,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_memwrite,
    input  logic             stall,
    input  logic             flush,
    output logic             mem_valid,
    output logic [DW-1:0]    mem_result,
    output logic [DW-1:0]    mem_store_data,
    output logic [4:0]       mem_rd,
    output logic             mem_regwrite,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_misalign,
    output logic             fwd_en,
    output logic [4:0]       fwd_rd,
    output logic [DW-1:0]    fwd_data,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [DW-1:0] sel_result;
    logic          misalign;
    logic          bubble;

    always_comb begin
        sel_result = alu_result;
        if (ex_opcode == 6'd0 && ex_funct == SRL_FUNCT)
            sel_result = shift_result;
    end

    assign misalign = (ex_memread | ex_memwrite) & (sel_result[1:0] != 2'b00);
    // Flush beats stall; an empty EX slot only becomes a bubble when not stalled.
    assign bubble   = flush | (~stall & ~ex_valid);

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_misalign   <= 1'b0;
            bubble_cnt     <= '0;
        end else if (bubble) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_misalign   <= 1'b0;
            if (bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else if (!stall) begin
            mem_valid      <= 1'b1;
            mem_result     <= sel_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_regwrite   <= ex_regwrite & (ex_rd != 5'd0);
            mem_memread    <= ex_memread;
            mem_memwrite   <= ex_memwrite & ~misalign;
            mem_misalign   <= misalign;
        end
    end

    // Load results are not forwarded from here; the MEM stage supplies them.
    assign fwd_en   = mem_valid & mem_regwrite & ~mem_memread;
    assign fwd_rd   = mem_rd;
    assign fwd_data = mem_result;

endmodule
